norgate: RTL and testbench

Parameterised bitwise XNOR (equivalence) unit with a registered result stage. It provides the combinational XNOR of two WIDTH-bit operands. It also registers the result together with an all-bits-equal flag and a count of matching bit positions. It serves as a leaf datapath primitive in the gate-level IP library, for bit-compare and match-scoring logic.

---
 rtl/norgate.sv | 78 +++++++
 tb/tb_norgate.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/norgate.sv
// -----------------------------------------------------------------------------
// norgate
// Bitwise XNOR (equivalence) unit with a registered result stage.
//
// The combinational output c is the per-bit equivalence of the operands. When
// in_valid is high, the rising clock edge also captures the XNOR vector, an
// all-bits-equal flag and the number of matching bit positions.
//
// Ports
//   clk        in   1      rising-edge clock for the registered stage
//   rst_n      in   1      asynchronous active-low reset for all registers
//   in_valid   in   1      qualifies a/b for capture
//   a, b       in   WIDTH  operands
//   c          out  WIDTH  combinational ~(a ^ b)
//   out_valid  out  1      registered outputs hold a freshly captured result
//   c_q        out  WIDTH  registered XNOR result
//   all_eq     out  1      registered a == b flag
//   match_cnt  out  CW     registered count of equal bit positions (0..WIDTH)
// -----------------------------------------------------------------------------
module norgate #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic [WIDTH-1:0] c_q,
    output logic             all_eq,
    output logic [CW-1:0]    match_cnt
);

    // Population count of the XNOR vector. CW bits always hold WIDTH, so the
    // running sum cannot overflow.
    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    logic [WIDTH-1:0] xnor_p0;
    logic             eq_p0;
    logic [CW-1:0]    cnt_p0;

    // Stage 0: combinational equivalence and its summaries.
    always_comb begin
        xnor_p0 = ~(a ^ b);
        eq_p0   = (a == b);
        cnt_p0  = popcount(xnor_p0);
    end

    assign c = xnor_p0;

    // Stage 1: result register. Data holds when in_valid is low; only the
    // valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c_q       <= '0;
            all_eq    <= 1'b0;
            match_cnt <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c_q       <= xnor_p0;
                all_eq    <= eq_p0;
                match_cnt <= cnt_p0;
            end
        end
    end

endmodule

// File: tb/tb_norgate.sv
module tb_norgate;

    localparam int WIDTH = 32;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic [WIDTH-1:0] c_q;
    logic             all_eq;
    logic [CW-1:0]    match_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    norgate #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .c(c), .out_valid(out_valid), .c_q(c_q), .all_eq(all_eq),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural reference: per-bit equality and a count of equal positions.
    function automatic logic [WIDTH-1:0] eq_bits(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = (x[i] == y[i]);
        return r;
    endfunction

    function automatic int eq_count(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) if (x[i] == y[i]) n++;
        return n;
    endfunction

    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_cq    = '0;
    logic             m_eq    = 1'b0;
    int               m_cnt   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_cq = '0; m_eq = 1'b0; m_cnt = 0;
        end else if (in_valid) begin
            m_valid = 1'b1;
            m_cq    = eq_bits(a, b);
            m_eq    = (a == b);
            m_cnt   = eq_count(a, b);
        end else begin
            m_valid = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("c_model", 64'(c), 64'(eq_bits(a, b)));
            check("out_valid_model", 64'(out_valid), 64'(m_valid));
            check("c_q_model", 64'(c_q), 64'(m_cq));
            check("all_eq_model", 64'(all_eq), 64'(m_eq));
            check("match_cnt_model", 64'(match_cnt), 64'(m_cnt));
            check("eq_invariant", 64'(all_eq), 64'(match_cnt == CW'(WIDTH)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c_q", 64'(c_q), 64'd0);
        check("rst_all_eq", 64'(all_eq), 64'd0);
        check("rst_match_cnt", 64'(match_cnt), 64'd0);

        // Combinational path, no clock involvement.
        a = 32'h00000000; b = 32'h00000000; #1 check("comb_00_00", 64'(c), 64'hFFFFFFFF);
        a = 32'hFFFFFFFF; b = 32'h00000000; #1 check("comb_FF_00", 64'(c), 64'h00000000);
        a = 32'h00000000; b = 32'hFFFFFFFF; #1 check("comb_00_FF", 64'(c), 64'h00000000);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; #1 check("comb_FF_FF", 64'(c), 64'hFFFFFFFF);

        step();
        rst_n = 1'b1;
        chk_en = 1'b1;

        a = 32'hAAAAAAAA; b = 32'h55555555; in_valid = 1'b1;
        step();
        check("alt_c", 64'(c), 64'h0);
        check("alt_c_q", 64'(c_q), 64'h0);
        check("alt_all_eq", 64'(all_eq), 64'd0);
        check("alt_cnt", 64'(match_cnt), 64'd0);
        check("alt_valid", 64'(out_valid), 64'd1);

        a = 32'h12345678; b = 32'h12345678;
        step();
        check("eq_c_q", 64'(c_q), 64'hFFFFFFFF);
        check("eq_all_eq", 64'(all_eq), 64'd1);
        check("eq_cnt", 64'(match_cnt), 64'd32);

        a = 32'h12345678; b = 32'h1234ABCD;
        step();
        check("mix_c", 64'(c), 64'hFFFF024A);
        check("mix_c_q", 64'(c_q), 64'hFFFF024A);
        check("mix_all_eq", 64'(all_eq), 64'd0);
        check("mix_cnt", 64'(match_cnt), 64'd20);

        // Three back-to-back captures, then one idle cycle.
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; in_valid = 1'b1;
            step();
            check("b2b_valid", 64'(out_valid), 64'd1);
        end
        a = 32'hDEADBEEF; b = 32'hDEADBEEF; in_valid = 1'b0;
        step();
        check("idle_valid", 64'(out_valid), 64'd0);
        check("idle_hold_cnt_ne32", 64'(all_eq && a != b), 64'd0);

        // Reset pulled between edges while a result is valid.
        a = 32'h0F0F0F0F; b = 32'h0F0F0F0F; in_valid = 1'b1;
        step();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_c_q", 64'(c_q), 64'd0);
        check("mid_rst_all_eq", 64'(all_eq), 64'd0);
        check("mid_rst_cnt", 64'(match_cnt), 64'd0);
        b = 32'h0F0F0F00; #1;
        check("mid_rst_c_tracks", 64'(c), 64'hFFFFFFF0);
        step();
        check("in_rst_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        a = 32'h00000001; b = 32'h00000000; in_valid = 1'b1;
        step();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_c_q", 64'(c_q), 64'hFFFFFFFE);
        check("post_rst_cnt", 64'(match_cnt), 64'd31);

        // Randomized traffic; sparse-difference operands exercise high counts.
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            in_valid = ($urandom_range(0, 3) != 0);
            step();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
